lf_edge_interval: RTL
=====================

LF_EDGE_INTERVAL -- requirements
Module: lf_edge_interval

Interface
REQ-001 Parameter ADC_W, default 8: width of the ADC sample and min/max inputs.
REQ-002 Parameter CNT_W, default 16: width of the edge-interval counter.
REQ-003 Parameter FIFO_DEPTH, default 4: interval FIFO entries; shall be a power of 2, at least 2.
REQ-004 Parameter MIN_SPAN, default 72: minimum (max-min) for edge detection to be enabled.
REQ-005 Parameter GLITCH_N, default 2: consecutive samples required by the glitch filter, at least 1.
REQ-006 clk  in  1  sole clock; all registers on posedge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 adc_d  in  ADC_W  ADC sample, one per clk.
REQ-009 min / max  in  ADC_W each  envelope from the external min/max tracker.
REQ-010 edge_mode  in  2  00 all edges, 01 rising only, 10 falling only, 11 none.
REQ-011 edge_state  out  1  last detected level: 1 high, 0 low.
REQ-012 edge_toggle  out  1  inverts once per qualifying edge.
REQ-013 iv_data  out  CNT_W+1  FIFO head: bit CNT_W = polarity (1 rising), lower bits = interval.
REQ-014 iv_valid / iv_ready  out / in  1 each  FIFO head valid / consumer accepts.
REQ-015 overflow  out  1  sticky: an edge was dropped because the FIFO was full.
REQ-016 enabled  out  1  detection enabled (combinational).

Function
REQ-017 span = max-min, mid = (max+min)>>1, both computed at ADC_W+1 bits without truncation.
REQ-018 Thresholds: high = mid+(span>>2), highz = mid+(span>>3), lowz = mid-(span>>3), low = mid-(span>>2).
REQ-019 enabled shall be 1 iff max>=min and span>=MIN_SPAN.
REQ-020 Registered compare each cycle: is_high = adc_d>=high; is_low = adc_d<=low; is_zero = lowz<adc_d<highz.
REQ-021 armed flag: an edge event shall occur when enabled, armed, and (is_high or is_low); armed then clears; otherwise armed |= is_zero.
REQ-022 Polarity: an event with is_high is rising; otherwise it is falling.
REQ-023 edge_state shall be set by is_high and cleared by is_low (is_high has priority), only while enabled.
REQ-024 Qualifying edge: an event whose polarity matches edge_mode; a non-matching event still clears armed but does not toggle or push.
REQ-025 Latency: adc_d sampled at edge k shall update edge_toggle/edge_state at edge k+1 (filter excluded); iv_valid shall rise at edge k+1 if the FIFO was empty.
REQ-026 Interval counter: +1 per clk, saturating at all-ones; on a qualifying edge, {polarity, count} is pushed and the counter loads 1.
REQ-027 The first interval after reset shall equal the cycles elapsed since reset release.
REQ-028 iv_valid = FIFO not empty; a pop occurs when iv_valid and iv_ready.
REQ-029 A push while full with no pop shall be dropped and shall set overflow; a push and a pop in the same cycle while full shall both succeed.
REQ-030 While enabled=0: armed, edge_state and edge_toggle hold; the counter runs; no pushes occur; FIFO pops continue.
REQ-031 An edge_mode change shall take effect on the next cycle.

Reset
REQ-032 Asserting rst shall immediately force: armed=1, edge_state=0, edge_toggle=0, counter=0, FIFO empty (iv_valid=0), overflow=0, flags and glitch counters 0.
REQ-033 overflow shall clear only on reset; a reset mid-burst shall discard all FIFO contents.

Configuration
REQ-034 Macro LF_EDGE_GLITCH_FILTER_EN: when defined, is_high/is_low shall reach the edge logic only after GLITCH_N consecutive cycles asserted, adding GLITCH_N-1 cycles of latency; when undefined, they pass directly and GLITCH_N is ignored.

Verification (min=40, max=200: high=160, highz=140, lowz=100, low=80)
REQ-035 adc 120 then 170 at edge k, mode 00 -> edge_toggle=1, edge_state=1 at edge k+1; iv_data bit CNT_W=1.
REQ-036 Sequence 170,150,170 -> one edge only; sequence 170,120,170 -> second edge, rising; interval equals the cycle distance.
REQ-037 min=100, max=160 (span 60) -> enabled=0; a 60..200 swing produces no toggle and no push.
REQ-038 Five qualifying edges with iv_ready=0 -> 4 entries held, overflow=1; then iv_ready=1 drains 4 in order, overflow stays 1.
REQ-039 Mode 01 with alternating 200/40 -> only rising entries; each interval spans two swings; toggle inverts once per rising edge.
REQ-040 One-cycle spike 120->200->120 with GLITCH_N=2 -> no edge with LF_EDGE_GLITCH_FILTER_EN defined, one edge without it.

Source files
------------

// File: rtl/lf_edge_interval.sv
// Edge detector on a min/max-normalised ADC stream with an interval FIFO.
// Optional glitch filter on the high/low flags: define LF_EDGE_GLITCH_FILTER_EN.
module lf_edge_interval #(
    parameter int ADC_W      = 8,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_SPAN   = 72,
    parameter int GLITCH_N   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] adc_d,
    input  logic [ADC_W-1:0] min,
    input  logic [ADC_W-1:0] max,
    input  logic [1:0]       edge_mode,
    output logic             edge_state,
    output logic             edge_toggle,
    output logic [CNT_W:0]   iv_data,
    output logic             iv_valid,
    input  logic             iv_ready,
    output logic             overflow,
    output logic             enabled
);
    localparam int W1 = ADC_W + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [W1-1:0] span, mid, th_high, th_highz, th_lowz, th_low, adc_x;
    logic          hi_q, lo_q, zero_q, hi_f, lo_f;
    logic          armed, edge_evt, mode_match, push, pop, full, wr_en;
    logic [CNT_W-1:0] cnt;
    logic [AW:0]   wp, rp;
    logic [CNT_W:0] mem [FIFO_DEPTH];

    // Thresholds carry one extra bit so max+min never truncates.
    assign span     = {1'b0, max} - {1'b0, min};
    assign mid      = ({1'b0, max} + {1'b0, min}) >> 1;
    assign th_high  = mid + (span >> 2);
    assign th_highz = mid + (span >> 3);
    assign th_lowz  = mid - (span >> 3);
    assign th_low   = mid - (span >> 2);
    assign adc_x    = {1'b0, adc_d};
    assign enabled  = (max >= min) && (span >= W1'(MIN_SPAN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= 1'b0;
            lo_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            hi_q   <= adc_x >= th_high;
            lo_q   <= adc_x <= th_low;
            zero_q <= (adc_x > th_lowz) && (adc_x < th_highz);
        end
    end

`ifdef LF_EDGE_GLITCH_FILTER_EN
    // Run counters hold how many earlier consecutive cycles the raw flag was set.
    localparam logic [7:0] RUN_MAX = 8'(GLITCH_N - 1);
    logic [7:0] hi_run, lo_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_run <= '0;
            lo_run <= '0;
        end else begin
            hi_run <= !hi_q ? 8'd0 : (hi_run == RUN_MAX) ? hi_run : hi_run + 8'd1;
            lo_run <= !lo_q ? 8'd0 : (lo_run == RUN_MAX) ? lo_run : lo_run + 8'd1;
        end
    end

    assign hi_f = hi_q && (hi_run >= RUN_MAX);
    assign lo_f = lo_q && (lo_run >= RUN_MAX);
`else
    // A GLITCH_N below 1 is illegal; such a build never reports high/low.
    assign hi_f = hi_q & (GLITCH_N >= 1);
    assign lo_f = lo_q & (GLITCH_N >= 1);
`endif

    assign edge_evt = enabled && armed && (hi_f || lo_f);

    always_comb begin
        mode_match = 1'b0;
        case (edge_mode)
            2'b00:   mode_match = 1'b1;
            2'b01:   mode_match = hi_f;
            2'b10:   mode_match = !hi_f;
            default: mode_match = 1'b0;
        endcase
    end

    assign push  = edge_evt && mode_match;
    assign pop   = iv_valid && iv_ready;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed       <= 1'b1;
            edge_state  <= 1'b0;
            edge_toggle <= 1'b0;
            cnt         <= '0;
            wp          <= '0;
            rp          <= '0;
            overflow    <= 1'b0;
        end else begin
            cnt <= push ? CNT_W'(1) : (&cnt) ? cnt : cnt + CNT_W'(1);
            if (enabled) begin
                if (edge_evt)    armed <= 1'b0;
                else if (zero_q) armed <= 1'b1;
                if (hi_f)        edge_state <= 1'b1;
                else if (lo_f)   edge_state <= 1'b0;
            end
            if (push)               edge_toggle <= ~edge_toggle;
            if (wr_en)              wp <= wp + 1'b1;
            if (pop)                rp <= rp + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= {hi_f, cnt};
    end

    assign iv_valid = wp != rp;
    assign iv_data  = mem[rp[AW-1:0]];
endmodule
